// File: rtl/cordic_phase_driver_if.sv
// rtl/cordic_phase_driver_if.sv - FIFO and sample-stream signal bundle for the CORDIC phase driver
//
// Ports (master = phase driver, slave = FIFOs / downstream sink):
//   p_fixed, in_wr_en           phase word and write strobe into the CORDIC input FIFO
//   in_full                     input FIFO full
//   sin_out, cos_out            output FIFO data (valid one cycle after rd_en)
//   sin_empty, cos_empty        output FIFO empty flags
//   sin_rd_en, cos_rd_en        output FIFO read strobes (always identical)
//   sample_sin, sample_cos      paired result presented downstream
//   sample_valid, sample_ready  downstream valid/ready handshake
interface cordic_phase_driver_if #(
    parameter int DATA_WIDTH = 16
);
    logic [31:0]           p_fixed;
    logic                  in_wr_en;
    logic                  in_full;
    logic [DATA_WIDTH-1:0] sin_out;
    logic [DATA_WIDTH-1:0] cos_out;
    logic                  sin_empty;
    logic                  cos_empty;
    logic                  sin_rd_en;
    logic                  cos_rd_en;
    logic [DATA_WIDTH-1:0] sample_sin;
    logic [DATA_WIDTH-1:0] sample_cos;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output p_fixed, in_wr_en, sin_rd_en, cos_rd_en,
               sample_sin, sample_cos, sample_valid,
        input  in_full, sin_out, cos_out, sin_empty, cos_empty, sample_ready
    );

    modport slave (
        input  p_fixed, in_wr_en, sin_rd_en, cos_rd_en,
               sample_sin, sample_cos, sample_valid,
        output in_full, sin_out, cos_out, sin_empty, cos_empty, sample_ready
    );
endinterface

// File: rtl/cordic_phase_driver.sv
// rtl/cordic_phase_driver.sv - phase generator and sin/cos result collector around a CORDIC core
//
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-low reset
//   start, stop                run control pulses (start honoured in IDLE, stop in RUN)
//   phase_init, phase_inc      signed Q16.16 start phase and per-sample increment
//   num_samples                samples to issue, 0 = run until stop
//   busy, done, desync_err     run status, completion pulse, sticky FIFO desync flag
//   bus (master)               CORDIC input FIFO writes, output FIFO reads, sample stream
module cordic_phase_driver #(
    parameter logic signed [31:0] PI_FIXED        = 32'sd205887,
    parameter int                 MAX_OUTSTANDING = 1024,
    parameter int                 DATA_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic signed [31:0]   phase_init,
    input  logic signed [31:0]   phase_inc,
    input  logic [31:0]          num_samples,
    output logic                 busy,
    output logic                 done,
    output logic                 desync_err,
    cordic_phase_driver_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic signed [31:0]    phase_q, phase_d;
    logic signed [31:0]    inc_q, inc_d;
    logic [31:0]           num_q, num_d;
    logic [31:0]           issued_q, issued_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic                  desync_q;
    logic                  live_q;
    logic                  rd_pending_q;
    logic [1:0]            buf_count_q, buf_count_d;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [2*DATA_WIDTH-1:0] buf_q [2];

    logic                  limit_hit, wr_en, rd_en, pop;
    logic [2:0]            occ;
    logic signed [32:0]    pi_s, sum_s, wrapped_s;

    assign limit_hit = (num_q != 32'd0) && (issued_q == num_q);
    assign wr_en     = (state_q == S_RUN) && !stop && !bus.in_full
                     && (outstanding_q < OUT_MAX) && !limit_hit;
    assign pop       = bus.sample_valid && bus.sample_ready;

    // Occupancy the buffer will have once this cycle's capture and pop settle; a read
    // issued now lands next cycle, so it may go out while that figure is below 2.
    // Crediting the pop is what lets a read go out every cycle at full throughput.
    assign occ   = {1'b0, buf_count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
    // live_q keeps the strobes low while reset is held, whatever the FIFO flags say.
    assign rd_en = live_q && !bus.sin_empty && !bus.cos_empty && (occ < 3'd2);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        inc_d     = inc_q;
        num_d     = num_q;
        issued_d  = issued_q;
        pi_s      = {PI_FIXED[31], PI_FIXED};
        sum_s     = {phase_q[31], phase_q} + {inc_q[31], inc_q};
        wrapped_s = sum_s;
        // Wrap into [-pi, +pi]; both endpoints are kept as-is.
        if (sum_s > pi_s) begin
            wrapped_s = sum_s - (pi_s + pi_s);
        end else if (sum_s < -pi_s) begin
            wrapped_s = sum_s + (pi_s + pi_s);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    phase_d  = phase_init;
                    inc_d    = phase_inc;
                    num_d    = num_samples;
                    issued_d = 32'd0;
                end
            end
            S_RUN: begin
                if (wr_en) begin
                    phase_d  = 32'(wrapped_s);
                    issued_d = issued_q + 32'd1;
                end
                if (stop || limit_hit) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (wr_en && !pop) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!wr_en && pop) begin
            outstanding_d = outstanding_q - OW'(1);
        end
        buf_count_d = buf_count_q + {1'b0, rd_pending_q} - {1'b0, pop};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            inc_q         <= '0;
            num_q         <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            desync_q      <= 1'b0;
            live_q        <= 1'b0;
            rd_pending_q  <= 1'b0;
            buf_count_q   <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            inc_q         <= inc_d;
            num_q         <= num_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            desync_q      <= desync_q | (bus.sin_empty != bus.cos_empty);
            live_q        <= 1'b1;
            rd_pending_q  <= rd_en;
            buf_count_q   <= buf_count_d;
            // FIFO dout belongs to the read strobed last cycle.
            if (rd_pending_q) begin
                buf_q[wr_ptr_q] <= {bus.sin_out, bus.cos_out};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign desync_err       = desync_q;
    assign bus.p_fixed      = phase_q;
    assign bus.in_wr_en     = wr_en;
    assign bus.sin_rd_en    = rd_en;
    assign bus.cos_rd_en    = rd_en;
    assign bus.sample_valid = (buf_count_q != 2'd0);
    assign bus.sample_sin   = buf_q[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.sample_cos   = buf_q[rd_ptr_q][DATA_WIDTH-1:0];
endmodule
